// File: rtl/incr_pipe_stage.sv
// Multi-channel registered add-step stage with skid buffer.
// Wrap/saturate arithmetic and per-channel overflow counters.
module incr_pipe_stage #(
  parameter int P_WIDTH     = 8,
  parameter int P_CHANNELS  = 4,
  parameter int P_SATURATE  = 0,
  parameter int P_OVF_CNT_W = 8,
  parameter int P_DELAY     = 1,
  localparam int CW = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
  input  logic                              CLK_I,
  input  logic                              RST_X,
  input  logic                              VALID_I,
  output logic                              READY_O,
  input  logic [P_WIDTH-1:0]                DATA_I,
  input  logic [P_WIDTH-1:0]                STEP_I,
  input  logic [CW-1:0]                     CHAN_I,
  output logic                              VALID_O,
  input  logic                              READY_I,
  output logic [P_WIDTH-1:0]                DATA_O,
  output logic [CW-1:0]                     CHAN_O,
  output logic                              OVF_O,
  input  logic                              CLR_I,
  output logic [P_CHANNELS*P_OVF_CNT_W-1:0] OVF_CNT_O
);

  typedef struct packed {
    logic [P_WIDTH-1:0] data;
    logic [CW-1:0]      chan;
    logic               ovf;
  } word_t;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } skid_st_e;

  localparam logic [P_OVF_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_OVF_CNT_W-1:0] CNT_ONE =
    P_OVF_CNT_W'(1);

  // Registers update on the clock edge itself; the
  // delay parameter is kept only for drop-in compatibility.
  logic unused_delay;
  assign unused_delay = (P_DELAY != 0);

  skid_st_e state_q, state_d;
  word_t    out_q, out_d;
  word_t    skid_q, skid_d;
  logic     out_vld_q, out_vld_d;
  logic     rdy_q, rdy_d;

  logic [P_OVF_CNT_W-1:0] cnt_q [P_CHANNELS];
  logic [P_OVF_CNT_W-1:0] cnt_d [P_CHANNELS];

  logic [P_WIDTH:0] sum;
  word_t            in_w;
  logic             acc;
  logic             cons;

  assign acc  = VALID_I & rdy_q;
  assign cons = out_vld_q & READY_I;

  // Form the result word at acceptance time.
  always_comb begin
    sum = {1'b0, DATA_I} + {1'b0, STEP_I};
    in_w.ovf  = sum[P_WIDTH];
    in_w.chan = CHAN_I;
    in_w.data = sum[P_WIDTH-1:0];
    if ((P_SATURATE != 0) && sum[P_WIDTH]) begin
      in_w.data = '1;
    end
  end

  // Output register plus one-entry skid; ready follows skid space.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skid_d    = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          if (!out_vld_q || READY_I) begin
            out_d     = in_w;
            out_vld_d = 1'b1;
          end else begin
            skid_d  = in_w;
            state_d = S_FULL;
          end
        end else if (cons) begin
          out_vld_d = 1'b0;
        end
      end
      S_FULL: begin
        if (cons) begin
          out_d   = skid_q;
          state_d = S_EMPTY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    rdy_d = (state_d == S_EMPTY);
  end

  // Saturating per-channel overflow counters; clear wins.
  always_comb begin
    for (int k = 0; k < P_CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (CLR_I) begin
        cnt_d[k] = '0;
      end else if (acc && in_w.ovf &&
                   (CHAN_I == CW'(k)) &&
                   (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + CNT_ONE;
      end
    end
  end

  // Pipeline and skid state.
  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= S_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      out_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      out_vld_q <= out_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  // Counter state.
  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      for (int k = 0; k < P_CHANNELS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < P_CHANNELS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign READY_O = rdy_q;
  assign VALID_O = out_vld_q;
  assign DATA_O  = out_q.data;
  assign CHAN_O  = out_q.chan;
  assign OVF_O   = out_q.ovf;

  for (genvar g = 0; g < P_CHANNELS; g++) begin : g_cnt
    assign OVF_CNT_O[g*P_OVF_CNT_W +: P_OVF_CNT_W] = cnt_q[g];
  end

endmodule
